seqmult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8x8 sequential multiplier among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues one load pulse per job to the multiplier. It waits for the multiplier's valid, then returns the 16-bit product tagged with the requester index over a single response handshake. It sits between the client blocks and the shared multiplier instance; only one job is in flight at a time.

---
 rtl/seqmult_arbiter.sv | 145 ++++++++++++++
 tb/tb_seqmult_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqmult_arbiter.sv
// seqmult_arbiter: round-robin front end for one shared 8x8 sequential multiplier.
// Accepts operand pairs from NREQ requesters, issues one mul_load per job, waits
// for mul_valid and returns the tagged 16-bit product over a single response
// handshake. Only one job is in flight at a time.
// Optional build macro SEQMULT_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// answers with rsp_err=1 after TIMEOUT cycles without mul_valid.
module seqmult_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_prod,
    output logic              rsp_err,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    output logic              mul_load,
    input  logic              mul_valid,
    input  logic [15:0]       mul_prod,
    output logic              busy
);

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("seqmult_arbiter: NREQ must be within 2..16");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("seqmult_arbiter: TIMEOUT must be within 2..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  winner;
    logic            win_found;

`ifdef SEQMULT_ARB_TIMEOUT_EN
    logic [7:0]      wait_cnt;
`endif

    // Round-robin search: first valid requester after last_grant, with wrap-around
    always_comb begin
        cand      = '0;
        winner    = '0;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_grant) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

    // One-hot accept, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && !reset) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Job sequencer: accept -> load pulse -> wait for product -> respond
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_prod   <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_load   <= 1'b0;
            busy       <= 1'b0;
`ifdef SEQMULT_ARB_TIMEOUT_EN
            rsp_err    <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            mul_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        mul_a    <= req_a[{winner, 3'b000} +: 8];
                        mul_b    <= req_b[{winner, 3'b000} +: 8];
                        rsp_id   <= winner;
                        mul_load <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SEQMULT_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_valid) begin
                        rsp_prod  <= mul_prod;
                        rsp_valid <= 1'b1;
`ifdef SEQMULT_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef SEQMULT_ARB_TIMEOUT_EN
                    // wait_cnt is the number of WAIT cycles already elapsed
                    else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        rsp_prod  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SEQMULT_ARB_TIMEOUT_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_seqmult_arbiter.sv
// tb_seqmult_arbiter: randomized and directed bench for seqmult_arbiter.
// A per-cycle reference model (round-robin rule, job phase counter, expected
// response record) is compared against the DUT on every falling edge.
module tb_seqmult_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_prod;
    logic              rsp_err;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic              mul_load;
    logic              mul_valid;
    logic [15:0]       mul_prod;
    logic              busy;

    seqmult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load),
        .mul_valid(mul_valid), .mul_prod(mul_prod), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    bit mon_en = 0;
    bit ref_busy, ref_resp;
    int since, ref_last;
    int cur_id, cur_a, cur_b, cur_prod;
    bit cur_err;
    int n_rsp = 0, n_loads = 0;
    int last_id, last_prod;
    bit last_err;
    bit acc_flag;
    int acc_id;
    int grants[$];
    bit oneshot = 1;
    int lat = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner = first valid index after 'last', wrapping
    function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input int last);
        logic [NREQ-1:0] res;
        res = '0;
        for (int d = 1; d <= NREQ; d++) begin
            if (res == '0 && v[(last + d) % NREQ]) res[(last + d) % NREQ] = 1'b1;
        end
        return res;
    endfunction

    // Multiplier model: answers 'lat' cycles after mul_load (lat 0 = never)
    initial begin
        int cd, pa, pb;
        cd = 0; pa = 0; pb = 0;
        mul_valid = 1'b0;
        mul_prod  = '0;
        forever begin
            @(posedge clk); #1;
            mul_valid = 1'b0;
            mul_prod  = 16'($urandom);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mul_valid = 1'b1;
                    mul_prod  = 16'(pa * pb);
                end
            end
            if (mul_load && lat != 0) begin
                cd = lat;
                pa = int'(mul_a);
                pb = int'(mul_b);
            end
        end
    end

    // Per-cycle comparison and reference update, sampled at the falling edge
    task automatic mon();
        logic [NREQ-1:0] exp_rdy;
        check("busy", busy, ref_busy);
        check("mul_load", mul_load, (ref_busy && since == 1));
        check("rsp_valid", rsp_valid, ref_resp);
        exp_rdy = ref_busy ? '0 : pick(req_valid, ref_last);
        check("req_ready", req_ready, exp_rdy);
        if (mul_load) n_loads++;
        if (ref_busy) begin
            check("mul_a", mul_a, cur_a);
            check("mul_b", mul_b, cur_b);
        end
        if (ref_resp) begin
            check("rsp_id", rsp_id, cur_id);
            check("rsp_prod", rsp_prod, cur_prod);
            check("rsp_err", rsp_err, cur_err);
        end
        acc_flag = 0;
        if (ref_resp) begin
            if (rsp_ready) begin
                last_id = cur_id; last_prod = cur_prod; last_err = cur_err;
                ref_last = cur_id;
                ref_busy = 0;
                ref_resp = 0;
                n_rsp++;
            end
        end else if (ref_busy) begin
            if (since >= 2) begin
                if (mul_valid) begin
                    ref_resp = 1;
                    cur_err  = 0;
                end
`ifdef SEQMULT_ARB_TIMEOUT_EN
                else if (since - 1 == TIMEOUT) begin
                    ref_resp = 1;
                    cur_err  = 1;
                    cur_prod = 0;
                end
`endif
            end
        end else if (exp_rdy != '0) begin
            for (int j = 0; j < NREQ; j++) begin
                if (exp_rdy[j]) begin
                    cur_id   = j;
                    cur_a    = int'(req_a[8*j +: 8]);
                    cur_b    = int'(req_b[8*j +: 8]);
                    cur_prod = cur_a * cur_b;
                    cur_err  = 0;
                    acc_id   = j;
                end
            end
            ref_busy = 1;
            since    = 0;
            acc_flag = 1;
            grants.push_back(acc_id);
        end
        if (ref_busy) since++;
    endtask

    task automatic step();
        @(negedge clk);
        if (mon_en) mon();
        @(posedge clk); #1;
        if (acc_flag && oneshot) req_valid[acc_id] = 1'b0;
    endtask

    task automatic do_reset();
        mon_en   = 0;
        acc_flag = 0;
        #2 reset = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_prod", rsp_prod, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_mul_load", mul_load, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset    = 1'b0;
        ref_busy = 0;
        ref_resp = 0;
        since    = 0;
        ref_last = NREQ - 1;
        mon_en   = 1;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget && n_rsp < target; i++) step();
        check("rsp_count", n_rsp, target);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
        req_valid[i]    = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset     = 1'b1;
        req_valid = 4'b1010;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9abc_def0;
        rsp_ready = 1'b1;
        do_reset();
        req_valid = '0;

        // Single request, latency 9
        lat = 9; oneshot = 1;
        base = n_loads;
        set_req(2, 12, 13);
        wait_rsp(n_rsp + 1, 100);
        check("t1_id", last_id, 2);
        check("t1_prod", last_prod, 156);
        check("t1_err", last_err, 0);
        check("t1_loads", n_loads - base, 1);

        // Round-robin fairness with everyone permanently valid
        do_reset();
        oneshot = 0; lat = 3;
        grants.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 10);
        wait_rsp(n_rsp + 5, 200);
        req_valid = '0;
        for (int k = 0; k < 5; k++) check("fair_grant", grants[k], k % NREQ);
        check("fair_last_prod", last_prod, 10);
        oneshot = 1;

        // Response backpressure, with another requester arriving meanwhile
        lat = 2; rsp_ready = 1'b0;
        set_req(1, 77, 3);
        for (int i = 0; i < 50 && !ref_resp; i++) step();
        check("t3_rsp_valid", rsp_valid, 1);
        set_req(3, 5, 6);
        repeat (5) step();
        rsp_ready = 1'b1;
        wait_rsp(n_rsp + 1, 10);
        check("t3_prod", last_prod, 231);
        wait_rsp(n_rsp + 1, 50);
        check("t3_next_id", last_id, 3);
        check("t3_next_prod", last_prod, 30);

        // Operand extremes
        lat = 4;
        set_req(0, 255, 255);
        wait_rsp(n_rsp + 1, 50);
        check("t4_max", last_prod, 65025);
        set_req(3, 0, 200);
        wait_rsp(n_rsp + 1, 50);
        check("t4_zero", last_prod, 0);

        // Reset while waiting; stale mul_valid must be ignored
        lat = 20;
        set_req(1, 7, 9);
        for (int i = 0; i < 30 && !(ref_busy && since >= 5); i++) step();
        check("t5_in_wait", busy, 1);
        do_reset();
        base = n_rsp;
        repeat (30) step();
        check("t5_no_rsp", n_rsp, base);
        lat = 5;
        set_req(0, 3, 4);
        wait_rsp(n_rsp + 1, 50);
        check("t5_id", last_id, 0);
        check("t5_prod", last_prod, 12);

        // Multiplier never answers
        lat = 0;
        set_req(2, 9, 9);
`ifdef SEQMULT_ARB_TIMEOUT_EN
        wait_rsp(n_rsp + 1, 100);
        check("t6_err", last_err, 1);
        check("t6_prod", last_prod, 0);
`else
        base = n_rsp;
        repeat (200) step();
        check("t6_no_rsp", n_rsp, base);
        check("t6_rsp_valid", rsp_valid, 0);
        do_reset();
`endif

        // Random traffic with random latency and backpressure
        oneshot = 1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255)),
                                   ($urandom_range(0, 7) == 0) ? 0   : int'($urandom_range(0, 255)));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 12);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && ref_busy; i++) step();
        check("drain_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
